// File: rtl/spi_slave_param.sv
// rtl/spi_slave_param.sv - system-clock sampled SPI slave bridging an SPI master to a RAM command port
// Frame: R/W bit, RX_W command bits MSB first; read-data frames then return DATA_W bits on miso.
module spi_slave_param #(
  parameter int DATA_W     = 8,
  parameter int TX_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ss_n,
  input  logic              mosi,
  output logic              miso,
  output logic [DATA_W+1:0] rx_data,
  output logic              rx_valid,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              rd_pending,
  output logic              frame_err
);

  localparam int RX_W  = DATA_W + 2;
  localparam int MAX_A = (RX_W > DATA_W) ? RX_W : DATA_W;
  localparam int MAX_C = (MAX_A > TX_TIMEOUT) ? MAX_A : TX_TIMEOUT;
  localparam int CNT_W = $clog2(MAX_C + 1);

  localparam logic [CNT_W-1:0] RX_LAST = CNT_W'(RX_W - 1);
  localparam logic [CNT_W-1:0] TX_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TX_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA, WAIT_TX, SEND, HOLD
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [RX_W-2:0]   rx_shift;
  logic [DATA_W-1:0] tx_shift;
  logic [RX_W-1:0]   rx_next;
  logic              abort;

  assign rx_next = {rx_shift, mosi};

  // Deselect is only an error while the frame still has work to do; HOLD and IDLE end cleanly.
  assign abort = ss_n && (state inside {CHK_CMD, WRITE, READ_ADD, READ_DATA, WAIT_TX, SEND});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      rx_shift   <= '0;
      tx_shift   <= '0;
      miso       <= 1'b0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      rd_pending <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      if (abort) begin
        state     <= IDLE;
        cnt       <= '0;
        miso      <= 1'b0;
        frame_err <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            miso <= 1'b0;
            cnt  <= '0;
            if (!ss_n) state <= CHK_CMD;
          end
          CHK_CMD: begin
            cnt <= '0;
            if (!mosi)          state <= WRITE;
            else if (rd_pending) state <= READ_DATA;
            else                 state <= READ_ADD;
          end
          WRITE, READ_ADD, READ_DATA: begin
            rx_shift <= rx_next[RX_W-2:0];
            if (cnt == RX_LAST) begin
              rx_data  <= rx_next;
              rx_valid <= 1'b1;
              cnt      <= '0;
              if (state == READ_DATA) begin
                state <= WAIT_TX;
              end else begin
                state <= HOLD;
                if (state == READ_ADD) rd_pending <= 1'b1;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          WAIT_TX: begin
            // Data arriving on the final wait cycle is still accepted.
            if (tx_valid) begin
              miso     <= tx_data[DATA_W-1];
              tx_shift <= {tx_data[DATA_W-2:0], 1'b0};
              cnt      <= '0;
              state    <= SEND;
            end else if (cnt == TO_LAST) begin
              frame_err <= 1'b1;
              cnt       <= '0;
              state     <= HOLD;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          SEND: begin
            if (cnt == TX_LAST) begin
              miso       <= 1'b0;
              rd_pending <= 1'b0;
              cnt        <= '0;
              state      <= HOLD;
            end else begin
              miso     <= tx_shift[DATA_W-1];
              tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
              cnt      <= cnt + 1'b1;
            end
          end
          HOLD: begin
            miso <= 1'b0;
            if (ss_n) state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
